// File: rtl/vmem_arbiter_if.sv
// Frame-buffer arbiter bus: display read, two pixel writers, clear control and RAM port.
// "slave" is the arbiter side; "master" is the surrounding system (VGA, writers, RAM).
interface vmem_arbiter_if #(
  parameter int AW         = 19,
  parameter int DW         = 24,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          disp_valid;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          wr0_valid;
  logic          wr0_ready;
  logic [AW-1:0] wr0_addr;
  logic [DW-1:0] wr0_data;
  logic          wr1_valid;
  logic          wr1_ready;
  logic [AW-1:0] wr1_addr;
  logic [DW-1:0] wr1_data;
  logic          clear_req;
  logic [DW-1:0] clear_color;
  logic          clear_busy;
  logic [LW-1:0] fifo_level;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  disp_valid, disp_addr, wr0_valid, wr0_addr, wr0_data,
           wr1_valid, wr1_addr, wr1_data, clear_req, clear_color, mem_rdata,
    output disp_data, wr0_ready, wr1_ready, clear_busy, fifo_level,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_valid, disp_addr, wr0_valid, wr0_addr, wr0_data,
           wr1_valid, wr1_addr, wr1_data, clear_req, clear_color, mem_rdata,
    input  disp_data, wr0_ready, wr1_ready, clear_busy, fifo_level,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vmem_arbiter.sv
// Single-port frame-buffer arbiter: display reads win every cycle, writer traffic is
// buffered in a small FIFO and drained (or a full-buffer clear is swept) in blanking cycles.
module vmem_arbiter #(
  parameter int AW         = 19,
  parameter int DW         = 24,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  vmem_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, CLEAR = 2'd2} state_t;

  state_t        state_q;
  logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [LW-1:0] level_q;
  logic [AW-1:0] clr_cnt_q;
  logic [DW-1:0] clr_color_q;
  logic          prio_q;      // 1: writer 1 is preferred when both request
  logic          disp_vld_q;

  logic          fifo_empty;
  logic          fifo_full;
  logic          enq_ok;
  logic          rdy0_d;
  logic          rdy1_d;
  logic          enq0_d;
  logic          enq1_d;
  logic          enq_d;
  logic          deq_d;
  logic          clr_wr_d;
  logic [AW-1:0] enq_addr_d;
  logic [DW-1:0] enq_data_d;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign enq_ok     = !rst && (state_q == IDLE) && !fifo_full;

  // Each ready looks only at the other writer's valid, so a requester never sees its own loop.
  assign rdy0_d     = enq_ok && (!bus.wr1_valid || !prio_q);
  assign rdy1_d     = enq_ok && (!bus.wr0_valid ||  prio_q);
  assign enq0_d     = rdy0_d && bus.wr0_valid;
  assign enq1_d     = rdy1_d && bus.wr1_valid;
  assign enq_d      = enq0_d || enq1_d;
  assign enq_addr_d = enq0_d ? bus.wr0_addr : bus.wr1_addr;
  assign enq_data_d = enq0_d ? bus.wr0_data : bus.wr1_data;

  assign clr_wr_d   = !rst && (state_q == CLEAR) && !bus.disp_valid;
  assign deq_d      = !rst && (state_q != CLEAR) && !bus.disp_valid && !fifo_empty;

  assign bus.wr0_ready  = rdy0_d;
  assign bus.wr1_ready  = rdy1_d;
  assign bus.clear_busy = (state_q != IDLE);
  assign bus.fifo_level = level_q;
  assign bus.disp_data  = disp_vld_q ? bus.mem_rdata : '0;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (!rst && bus.disp_valid) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.disp_addr;
    end else if (clr_wr_d) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = clr_cnt_q;
      bus.mem_wdata = clr_color_q;
    end else if (deq_d) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = fifo_addr_q[rd_ptr_q];
      bus.mem_wdata = fifo_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      clr_cnt_q  <= '0;
      prio_q     <= 1'b0;
      disp_vld_q <= 1'b0;
    end else begin
      disp_vld_q <= bus.disp_valid;
      if (enq_d) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        prio_q   <= enq0_d;
      end
      if (deq_d) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (enq_d && !deq_d)      level_q <= level_q + 1'b1;
      else if (!enq_d && deq_d) level_q <= level_q - 1'b1;
      case (state_q)
        IDLE:  if (bus.clear_req) state_q <= FLUSH;
        FLUSH: if (fifo_empty) state_q <= CLEAR;
        CLEAR: if (clr_wr_d) begin
                 clr_cnt_q <= clr_cnt_q + 1'b1;
                 if (&clr_cnt_q) state_q <= IDLE;
               end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data-only storage: no reset needed, contents are qualified by pointers/level.
  always_ff @(posedge clk) begin
    if (enq_d) begin
      fifo_addr_q[wr_ptr_q] <= enq_addr_d;
      fifo_data_q[wr_ptr_q] <= enq_data_d;
    end
    if ((state_q == IDLE) && bus.clear_req) clr_color_q <= bus.clear_color;
  end
endmodule

// File: tb/tb_vmem_arbiter.sv
// Bench for vmem_arbiter: table-driven display reads, directed grant/FIFO/clear/reset
// sequences, and a randomized run against a queue-based reference model.
module tb_vmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 24;
  localparam int FD = 4;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vmem_arbiter_if #(.AW(AW), .DW(DW), .FIFO_DEPTH(FD)) bus();
  vmem_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(FD)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Synchronous-read RAM with a backdoor write port for preloading
  logic [DW-1:0] ram [NW];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= ram[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  logic [AW+DW-1:0] w0_q[$];
  logic [AW+DW-1:0] w1_q[$];
  logic [AW+DW-1:0] wl[$];
  int               gnt_q[$];
  int               max_level;
  int               busy_rdy_bad;

  logic          s_dv, s_en, s_we, s_v0, s_v1, s_r0, s_r1, s_busy;
  logic [AW-1:0] s_daddr, s_addr;
  logic [DW-1:0] s_wdata;
  logic [AW+DW-1:0] s_w0, s_w1;
  logic [3:0]    s_level;

  function automatic logic [AW+DW-1:0] wl_at(input int i);
    return (i < wl.size()) ? wl[i] : '1;
  endfunction

  // One clock: drive writers from their queues, sample at negedge, advance past posedge.
  task automatic cyc();
    bus.wr0_valid = (w0_q.size() > 0);
    if (w0_q.size() > 0) {bus.wr0_addr, bus.wr0_data} = w0_q[0];
    bus.wr1_valid = (w1_q.size() > 0);
    if (w1_q.size() > 0) {bus.wr1_addr, bus.wr1_data} = w1_q[0];
    @(negedge clk);
    s_dv = bus.disp_valid;  s_daddr = bus.disp_addr;
    s_en = bus.mem_en;      s_we = bus.mem_we;
    s_addr = bus.mem_addr;  s_wdata = bus.mem_wdata;
    s_v0 = bus.wr0_valid;   s_v1 = bus.wr1_valid;
    s_r0 = bus.wr0_ready;   s_r1 = bus.wr1_ready;
    s_w0 = {bus.wr0_addr, bus.wr0_data};
    s_w1 = {bus.wr1_addr, bus.wr1_data};
    s_level = 4'(bus.fifo_level);
    s_busy = bus.clear_busy;
    if (s_en && s_we) wl.push_back({s_addr, s_wdata});
    if (int'(s_level) > max_level) max_level = int'(s_level);
    if (s_busy && (s_r0 || s_r1)) busy_rdy_bad++;
    if (s_v0 && s_r0) begin gnt_q.push_back(0); void'(w0_q.pop_front()); end
    if (s_v1 && s_r1) begin gnt_q.push_back(1); void'(w1_q.pop_front()); end
    @(posedge clk);
    #1;
    bus.clear_req = 1'b0;
  endtask

  typedef struct {
    logic          dv;
    logic [AW-1:0] a;
    logic [DW-1:0] exp_next;
  } rd_vec_t;
  rd_vec_t tv[6];

  logic [DW-1:0]    ref_ram [NW];
  logic [AW+DW-1:0] m_q[$];
  int               last_served, sz, holder, bad, found;
  logic             exp_r0, exp_r1, exp_we, busy_after;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    bus.disp_valid = 1'b0; bus.disp_addr = '0;
    bus.wr0_valid = 1'b1; bus.wr0_addr = '0; bus.wr0_data = '0;
    bus.wr1_valid = 1'b1; bus.wr1_addr = '0; bus.wr1_data = '0;
    bus.clear_req = 1'b0; bus.clear_color = '0;
    bus.disp_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_clear_busy", bus.clear_busy, 0);
    chk("rst_fifo_level", bus.fifo_level, 0);
    chk("rst_disp_data", bus.disp_data, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_wr0_ready", bus.wr0_ready, 0);
    chk("rst_wr1_ready", bus.wr1_ready, 0);
    bus.disp_valid = 1'b0; bus.wr0_valid = 1'b0; bus.wr1_valid = 1'b0;

    // Preload read targets through the backdoor while reset is held
    bd_we = 1'b1;
    bd_addr = 8'h05; bd_data = 24'hABCDEF; @(posedge clk); #1;
    bd_addr = 8'h07; bd_data = 24'h112233; @(posedge clk); #1;
    bd_addr = 8'h08; bd_data = 24'h445566; @(posedge clk); #1;
    bd_we = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Display read path, table driven
    tv[0] = '{1'b1, 8'h05, 24'hABCDEF};
    tv[1] = '{1'b0, 8'h05, 24'h000000};
    tv[2] = '{1'b1, 8'h07, 24'h112233};
    tv[3] = '{1'b1, 8'h08, 24'h445566};
    tv[4] = '{1'b1, 8'h05, 24'hABCDEF};
    tv[5] = '{1'b0, 8'h09, 24'h000000};
    for (int i = 0; i < 6; i++) begin
      bus.disp_valid = tv[i].dv;
      bus.disp_addr  = tv[i].a;
      cyc();
      chk("rd_mem_en", s_en, tv[i].dv);
      chk("rd_mem_we", s_we, 0);
      if (tv[i].dv) chk("rd_mem_addr", s_addr, tv[i].a);
      chk("rd_disp_data", bus.disp_data, tv[i].exp_next);
    end

    // Both writers valid: grants alternate starting with writer 0
    bus.disp_valid = 1'b0;
    max_level = 0; gnt_q.delete(); wl.delete();
    w0_q.push_back({8'h10, 24'h0000A0}); w0_q.push_back({8'h11, 24'h0000A1});
    w1_q.push_back({8'h12, 24'h0000B0}); w1_q.push_back({8'h13, 24'h0000B1});
    for (int k = 0; k < 20 && !(w0_q.size() == 0 && w1_q.size() == 0 && wl.size() == 4); k++) cyc();
    for (int i = 0; i < 4; i++) chk("rr_grant", (i < gnt_q.size()) ? gnt_q[i] : 9, i % 2);
    chk("rr_wr0", wl_at(0), {8'h10, 24'h0000A0});
    chk("rr_wr1", wl_at(1), {8'h12, 24'h0000B0});
    chk("rr_wr2", wl_at(2), {8'h11, 24'h0000A1});
    chk("rr_wr3", wl_at(3), {8'h13, 24'h0000B1});
    chk("rr_max_level_le1", (max_level <= 1), 1);

    // Display busy: FIFO fills to 4 and stalls, then drains in order
    bus.disp_valid = 1'b1; wl.delete();
    for (int i = 0; i < 6; i++) w0_q.push_back({8'(8'h20 + i), 24'(24'h300000 + i)});
    for (int k = 0; k < 10; k++) cyc();
    chk("full_accepted", 6 - w0_q.size(), 4);
    chk("full_level", bus.fifo_level, 4);
    chk("full_ready0", bus.wr0_ready, 0);
    chk("full_no_drain", wl.size(), 0);
    bus.disp_valid = 1'b0;
    cyc();
    chk("full_first_drain", wl.size(), 1);
    for (int k = 0; k < 20 && wl.size() < 6; k++) cyc();
    for (int i = 0; i < 6; i++) chk("full_order", wl_at(i), {8'(8'h20 + i), 24'(24'h300000 + i)});
    chk("full_level_end", bus.fifo_level, 0);

    // Clear with two pending entries; a second clear_req mid-sweep is ignored
    bus.disp_valid = 1'b1; wl.delete();
    w0_q.push_back({8'h40, 24'hDD0040}); w0_q.push_back({8'h41, 24'hDD0041});
    cyc(); cyc();
    chk("clr_pre_level", bus.fifo_level, 2);
    bus.disp_valid = 1'b0; bus.clear_color = 24'h123456; bus.clear_req = 1'b1;
    busy_rdy_bad = 0;
    cyc();
    w1_q.push_back({8'h50, 24'h777777});
    found = 0; busy_after = 1'b1;
    for (int k = 0; k < 2000 && bus.clear_busy; k++) begin
      bus.disp_valid = ($urandom_range(0, 99) < 40);
      bus.disp_addr = 8'($urandom);
      if (k == 100) begin bus.clear_req = 1'b1; bus.clear_color = 24'h654321; end
      cyc();
      if (s_we && s_addr == 8'hFF && s_busy) begin found = 1; busy_after = bus.clear_busy; end
    end
    chk("clr_busy_at_last", found, 1);
    chk("clr_busy_after_last", busy_after, 0);
    chk("clr_flush_0", wl_at(0), {8'h40, 24'hDD0040});
    chk("clr_flush_1", wl_at(1), {8'h41, 24'hDD0041});
    chk("clr_write_count", wl.size(), 258);
    bad = 0;
    for (int i = 0; i < 256; i++) if (wl_at(i + 2) !== {8'(i), 24'h123456}) bad++;
    chk("clr_sweep_bad", bad, 0);
    chk("clr_ready_while_busy", busy_rdy_bad, 0);
    bus.disp_valid = 1'b0;
    for (int k = 0; k < 20 && wl.size() < 259; k++) cyc();
    chk("clr_post_write", wl_at(258), {8'h50, 24'h777777});
    bad = 0;
    for (int a = 0; a < NW; a++) begin
      bus.disp_valid = 1'b1; bus.disp_addr = 8'(a);
      cyc();
      if (bus.disp_data !== ((a == 8'h50) ? 24'h777777 : 24'h123456)) bad++;
    end
    chk("clr_readback_bad", bad, 0);

    // Reset in the middle of a sweep, then a fresh sweep from address 0
    bus.disp_valid = 1'b0; wl.delete();
    bus.clear_color = 24'h0000AA; bus.clear_req = 1'b1;
    cyc();
    for (int k = 0; k < 200 && wl.size() < 8'h40; k++) cyc();
    chk("mid_last_addr", wl_at(8'h3F) >> DW, 8'h3F);
    bus.disp_valid = 1'b1; bus.disp_addr = 8'h00;
    cyc();
    chk("mid_disp_before", bus.disp_data, 24'h0000AA);
    chk("mid_busy_before", bus.clear_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.clear_busy, 0);
    chk("mid_rst_level", bus.fifo_level, 0);
    chk("mid_rst_disp", bus.disp_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.disp_valid = 1'b0; wl.delete();
    bus.clear_color = 24'hC2C2C2; bus.clear_req = 1'b1;
    cyc();
    for (int k = 0; k < 400 && bus.clear_busy; k++) cyc();
    chk("restart_busy_done", bus.clear_busy, 0);
    chk("restart_count", wl.size(), 256);
    bad = 0;
    for (int i = 0; i < 256; i++) if (wl_at(i) !== {8'(i), 24'hC2C2C2}) bad++;
    chk("restart_sweep_bad", bad, 0);

    // Randomized traffic against the reference model
    for (int i = 0; i < NW; i++) ref_ram[i] = 24'hC2C2C2;
    m_q.delete();
    last_served = 1;
    for (int n = 0; n < 600; n++) begin
      bus.disp_valid = ($urandom_range(0, 99) < 55);
      bus.disp_addr = 8'($urandom);
      if (w0_q.size() == 0 && $urandom_range(0, 1) == 1) w0_q.push_back({8'($urandom), 24'($urandom)});
      if (w1_q.size() == 0 && $urandom_range(0, 1) == 1) w1_q.push_back({8'($urandom), 24'($urandom)});
      cyc();
      sz = m_q.size();
      exp_we = !s_dv && (sz > 0);
      chk("rnd_level", s_level, sz);
      chk("rnd_mem_en", s_en, s_dv || (sz > 0));
      chk("rnd_mem_we", s_we, exp_we);
      if (exp_we) chk("rnd_drain", {s_addr, s_wdata}, m_q[0]);
      if (s_v0 && !s_v1)      holder = 0;
      else if (s_v1 && !s_v0) holder = 1;
      else                    holder = (last_served == 0) ? 1 : 0;
      exp_r0 = (sz < FD) && (holder == 0);
      exp_r1 = (sz < FD) && (holder == 1);
      if (s_v0) chk("rnd_ready0", s_r0, exp_r0);
      if (s_v1) chk("rnd_ready1", s_r1, exp_r1);
      chk("rnd_disp_data", bus.disp_data, s_dv ? ref_ram[s_daddr] : 24'h0);
      if (exp_we) begin
        ref_ram[m_q[0][AW+DW-1:DW]] = m_q[0][DW-1:0];
        void'(m_q.pop_front());
      end
      if (s_v0 && exp_r0) begin m_q.push_back(s_w0); last_served = 0; end
      else if (s_v1 && exp_r1) begin m_q.push_back(s_w1); last_served = 1; end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vmem_arbiter.md
Name:
vmem_arbiter

Overview:
- Shares the single-port video frame buffer between the VGA scan-out read path, two pixel writers (keyboard text renderer, CPU/debug writer) and a built-in clear engine.
- Sits between vga_ctrl/top-level addressing and the frame-buffer RAM; the RAM has a 1-cycle synchronous read.
- Scan-out has absolute priority. Writes are buffered in a small FIFO and drained to the RAM only in non-display cycles.

Parameters:
AW, 19, frame-buffer address width ({h_addr[9:0], v_addr[8:0]})
DW, 24, pixel width (RGB888)
FIFO_DEPTH, 4, write-buffer entries (power of 2, >=2)

Ports:
clk  in  1  system clock (pixel clock)
rst  in  1  asynchronous active-high reset
disp_valid  in  1  VGA active-area flag; display read required this cycle
disp_addr  in  AW  display read address
disp_data  out  DW  pixel returned 1 cycle after disp_valid
wr0_valid  in  1  writer 0 request
wr0_ready  out  1  writer 0 accepted this cycle
wr0_addr  in  AW  writer 0 address
wr0_data  in  DW  writer 0 pixel
wr1_valid / wr1_ready / wr1_addr / wr1_data  as writer 0, writer 1
clear_req  in  1  single-cycle pulse: fill whole buffer
clear_color  in  DW  fill colour, sampled when clear_req is accepted
clear_busy  out  1  high from clear acceptance until the last clear write
fifo_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data (1-cycle latency)

Behaviour:
- Reset values (async, immediate): state=IDLE, FIFO empty, fifo_level=0, clear counter=0, clear_busy=0, disp_data=0, round-robin pointer=writer 0, mem_en=mem_we=0, wr*_ready=0.
- Per-cycle RAM port priority: display > clear write > FIFO drain. The mem_* outputs are combinational from the current state and FIFO head.
- Display path:
  - disp_valid=1: mem_en=1, mem_we=0, mem_addr=disp_addr. Next cycle, disp_data=mem_rdata (registered).
  - disp_valid=0: disp_data=0 next cycle (black).
- States:
  - IDLE: enqueue allowed. Drain FIFO head when disp_valid=0 and FIFO non-empty.
  - FLUSH: entered on clear_req in IDLE. Enqueue blocked (both ready=0). Drain continues. Go to CLEAR when FIFO is empty.
  - CLEAR: on each non-display cycle, write clear_color at the counter address, then increment. After writing address 2^AW-1, the counter wraps to 0 and the state returns to IDLE. Enqueue stays blocked.
- clear_busy=1 in FLUSH and CLEAR.
- clear_req outside IDLE is ignored. Old FIFO writes always land before any clear write.
- Enqueue rules:
  - wrN_ready=1 only in IDLE, FIFO not full, and writer N holds the grant.
  - Grant: if only one writer is valid, it wins. If both are valid, the writer not served last wins.
  - The pointer updates only on a completed handshake (valid & ready).
  - ready never depends on the requester's own valid.
  - Writers hold valid/addr/data stable until ready.
- At most one enqueue and one dequeue per cycle.
- Full FIFO: no enqueue, even if a dequeue happens the same cycle (no bypass). Empty FIFO: no drain, mem_we=0.
- Simultaneous enqueue+dequeue at a non-full, non-empty level: fifo_level unchanged.
- A FIFO write to the same address as a concurrent display read is deferred by display priority. Display may read stale data for that cycle.
- rst mid-CLEAR: aborts immediately. RAM stays partly cleared. FIFO contents are discarded.

Test Plan:
- Reset, then disp_valid=1 with addr 0x00005 and RAM[5]=0xABCDEF -> disp_data=0xABCDEF exactly 1 cycle later; mem_we=0 throughout.
- Both writers valid continuously, disp_valid=0 -> grants alternate 0,1,0,1; RAM receives the four writes in that order; fifo_level never exceeds 1.
- disp_valid=1 for 10 cycles, writer 0 pushes 6 entries -> 4 accepted, then ready=0 with fifo_level=4; all 4 drain in order starting the first cycle disp_valid=0, then the remaining 2 are accepted.
- 2 entries in FIFO, clear_req with clear_color=0x123456 -> FLUSH writes both entries first, then CLEAR; wr*_ready=0 throughout; clear_busy falls after address 0x7FFFF is written; every location reads 0x123456.
- clear_req while clear_busy=1 -> ignored; only one sweep occurs.
- rst pulse mid-CLEAR at counter 0x00100 -> clear_busy=0, fifo_level=0, disp_data=0 immediately; a new clear_req restarts from address 0.
